// File: rtl/uart_ascii_report_sender.sv
// Report sender for the ASCII command path: echoes loopback bytes and formats
// watch / SR04 / temperature / humidity values into CRLF-terminated lines for uart_tx.
module uart_ascii_report_sender #(
  parameter int LOOP_FIFO_DEPTH = 16,
  parameter int LOOPBACK_EN     = 1
) (
  input  logic       iClk,
  input  logic       iRstn,
  input  logic [7:0] iLoopData,
  input  logic       iLoopValid,
  input  logic       iReqWatchRpt,
  input  logic       iReqSr04Rpt,
  input  logic       iReqTempRpt,
  input  logic       iReqHumRpt,
  input  logic [4:0] iWatchHour,
  input  logic [5:0] iWatchMin,
  input  logic [5:0] iWatchSec,
  input  logic [8:0] iSr04Cm,
  input  logic [7:0] iTempC,
  input  logic [7:0] iHumPct,
  output logic [7:0] oTxData,
  output logic       oTxValid,
  input  logic       iTxReady,
  output logic       oBusy,
  output logic       oLoopDrop
);

  localparam int              AW       = $clog2(LOOP_FIFO_DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(LOOP_FIFO_DEPTH);
  localparam bit              LOOP_ON  = (LOOPBACK_EN != 0);

  typedef enum logic [2:0] {IDLE, SNAP, CONV, SEND, ECHO} stateT;
  typedef enum logic [1:0] {RPT_WATCH, RPT_SR04, RPT_TEMP, RPT_HUM} rptT;

  stateT       state;
  rptT         rptKind;
  logic [3:0]  byteIdx;
  logic [3:0]  shiftCnt;
  logic [1:0]  fieldIdx;
  logic [8:0]  convBin;
  logic [11:0] convBcd;
  logic [11:0] bcdNext;
  logic [8:0]  snapF1;
  logic [8:0]  snapF2;
  logic [11:0] bcdF0;
  logic [7:0]  bcdF1;
  logic [7:0]  bcdF2;
  logic [8:0]  selVal [3];

  logic [3:0]  pend;
  logic [3:0]  reqVec;
  logic [3:0]  pendClr;

  logic [7:0]  fifoMem [LOOP_FIFO_DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        fifoEmpty;
  logic        fifoFull;
  logic        fifoWr;
  logic        fifoRd;
  logic [7:0]  fifoHead;
  logic        txFire;

  // ---------------------------------------------------------------------------
  // Helpers: double-dabble step and line formatting
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] dabAdj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [11:0] dabStep(input logic [11:0] bcd, input logic inBit);
    logic [11:0] adj;
    adj = {dabAdj(bcd[11:8]), dabAdj(bcd[7:4]), dabAdj(bcd[3:0])};
    return (adj << 1) | {11'd0, inBit};
  endfunction

  function automatic logic [7:0] asc(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  function automatic logic [3:0] lineLast(input rptT kind);
    unique case (kind)
      RPT_WATCH: return 4'd11;
      RPT_SR04:  return 4'd8;
      default:   return 4'd7;
    endcase
  endfunction

  function automatic logic [7:0] lineByte(input rptT kind, input logic [3:0] idx,
                                          input logic [11:0] f0, input logic [7:0] f1,
                                          input logic [7:0] f2);
    logic [7:0] b;
    b = 8'h0A;
    if (kind == RPT_WATCH) begin
      case (idx)
        4'd0:    b = "W";
        4'd1:    b = " ";
        4'd2:    b = asc(f0[7:4]);
        4'd3:    b = asc(f0[3:0]);
        4'd4:    b = ":";
        4'd5:    b = asc(f1[7:4]);
        4'd6:    b = asc(f1[3:0]);
        4'd7:    b = ":";
        4'd8:    b = asc(f2[7:4]);
        4'd9:    b = asc(f2[3:0]);
        4'd10:   b = 8'h0D;
        default: b = 8'h0A;
      endcase
    end else begin
      // Single-field lines share "X NNN" and differ only in the suffix.
      case (idx)
        4'd0: begin
          unique case (kind)
            RPT_SR04: b = "D";
            RPT_TEMP: b = "T";
            default:  b = "H";
          endcase
        end
        4'd1: b = " ";
        4'd2: b = asc(f0[11:8]);
        4'd3: b = asc(f0[7:4]);
        4'd4: b = asc(f0[3:0]);
        4'd5: begin
          unique case (kind)
            RPT_SR04: b = "c";
            RPT_TEMP: b = "C";
            default:  b = "%";
          endcase
        end
        4'd6:    b = (kind == RPT_SR04) ? "m" : 8'h0D;
        4'd7:    b = (kind == RPT_SR04) ? 8'h0D : 8'h0A;
        default: b = 8'h0A;
      endcase
    end
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Loopback FIFO
  // ---------------------------------------------------------------------------
  assign txFire    = oTxValid && iTxReady;
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = ((wrPtr - rdPtr) == FULL_CNT);
  // NOTE: full is judged before this cycle's pop, so a write racing a pop on a full FIFO is dropped.
  assign fifoWr    = LOOP_ON && iLoopValid && !fifoFull;
  assign fifoRd    = (state == ECHO) && txFire;
  assign fifoHead  = fifoMem[rdPtr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers define what is valid.
  always_ff @(posedge iClk) begin
    if (fifoWr) fifoMem[wrPtr[AW-1:0]] <= iLoopData;
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      oLoopDrop <= 1'b0;
    end else begin
      if (fifoWr) wrPtr <= wrPtr + 1'b1;
      if (fifoRd) rdPtr <= rdPtr + 1'b1;
      oLoopDrop <= LOOP_ON && iLoopValid && fifoFull;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latching
  // ---------------------------------------------------------------------------
  assign reqVec  = {iReqHumRpt, iReqTempRpt, iReqSr04Rpt, iReqWatchRpt};
  assign pendClr = (state == SNAP) ? (4'b0001 << rptKind) : 4'b0000;

  // A pulse coinciding with the clear wins, so the report is sent again.
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) pend <= 4'b0000;
    else        pend <= (pend & ~pendClr) | reqVec;
  end

  assign oBusy = (state != IDLE) || !fifoEmpty || (|pend);

  // ---------------------------------------------------------------------------
  // Field selection and conversion datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    selVal[0] = '0;
    selVal[1] = '0;
    selVal[2] = '0;
    unique case (rptKind)
      RPT_WATCH: begin
        selVal[0] = {4'd0, iWatchHour};
        selVal[1] = {3'd0, iWatchMin};
        selVal[2] = {3'd0, iWatchSec};
      end
      RPT_SR04: selVal[0] = iSr04Cm;
      RPT_TEMP: selVal[0] = {1'b0, iTempC};
      default:  selVal[0] = {1'b0, iHumPct};
    endcase
  end

  assign bcdNext = dabStep(convBcd, convBin[8]);

  // ---------------------------------------------------------------------------
  // Control FSM with registered TX outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state    <= IDLE;
      rptKind  <= RPT_WATCH;
      byteIdx  <= '0;
      shiftCnt <= '0;
      fieldIdx <= '0;
      convBin  <= '0;
      convBcd  <= '0;
      snapF1   <= '0;
      snapF2   <= '0;
      bcdF0    <= '0;
      bcdF1    <= '0;
      bcdF2    <= '0;
      oTxData  <= 8'h00;
      oTxValid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifoEmpty) begin
            oTxData  <= fifoHead;
            oTxValid <= 1'b1;
            state    <= ECHO;
          end else if (|pend) begin
            state <= SNAP;
            if (pend[0])      rptKind <= RPT_WATCH;
            else if (pend[1]) rptKind <= RPT_SR04;
            else if (pend[2]) rptKind <= RPT_TEMP;
            else              rptKind <= RPT_HUM;
          end
        end

        SNAP: begin
          convBin  <= selVal[0];
          snapF1   <= selVal[1];
          snapF2   <= selVal[2];
          convBcd  <= '0;
          shiftCnt <= '0;
          fieldIdx <= '0;
          state    <= CONV;
        end

        CONV: begin
          convBin  <= convBin << 1;
          convBcd  <= bcdNext;
          shiftCnt <= shiftCnt + 4'd1;
          if (shiftCnt == 4'd8) begin
            shiftCnt <= '0;
            convBcd  <= '0;
            case (fieldIdx)
              2'd0:    bcdF0 <= bcdNext;
              2'd1:    bcdF1 <= bcdNext[7:0];
              default: bcdF2 <= bcdNext[7:0];
            endcase
            if (rptKind == RPT_WATCH && fieldIdx != 2'd2) begin
              fieldIdx <= fieldIdx + 2'd1;
              convBin  <= (fieldIdx == 2'd0) ? snapF1 : snapF2;
            end else begin
              // The leading letter does not depend on the digits still being written.
              byteIdx  <= '0;
              oTxData  <= lineByte(rptKind, 4'd0, bcdF0, bcdF1, bcdF2);
              oTxValid <= 1'b1;
              state    <= SEND;
            end
          end
        end

        SEND: begin
          if (txFire) begin
            if (byteIdx == lineLast(rptKind)) begin
              oTxValid <= 1'b0;
              state    <= IDLE;
            end else begin
              byteIdx <= byteIdx + 4'd1;
              oTxData <= lineByte(rptKind, byteIdx + 4'd1, bcdF0, bcdF1, bcdF2);
            end
          end
        end

        ECHO: begin
          if (txFire) begin
            oTxValid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_ascii_report_sender.sv
// Scoreboard bench for uart_ascii_report_sender: a string-level line model fills an
// expected-byte queue and a monitor pops it on every TX handshake.
module tb_uart_ascii_report_sender;

  logic       iClk = 1'b0;
  logic       iRstn = 1'b0;
  logic [7:0] iLoopData = 8'h00;
  logic       iLoopValid = 1'b0;
  logic       iReqWatchRpt = 1'b0;
  logic       iReqSr04Rpt = 1'b0;
  logic       iReqTempRpt = 1'b0;
  logic       iReqHumRpt = 1'b0;
  logic [4:0] iWatchHour = '0;
  logic [5:0] iWatchMin = '0;
  logic [5:0] iWatchSec = '0;
  logic [8:0] iSr04Cm = '0;
  logic [7:0] iTempC = '0;
  logic [7:0] iHumPct = '0;
  logic [7:0] oTxData;
  logic       oTxValid;
  logic       iTxReady = 1'b0;
  logic       oBusy;
  logic       oLoopDrop;

  uart_ascii_report_sender #(.LOOP_FIFO_DEPTH(16), .LOOPBACK_EN(1)) dut (
    .iClk(iClk), .iRstn(iRstn),
    .iLoopData(iLoopData), .iLoopValid(iLoopValid),
    .iReqWatchRpt(iReqWatchRpt), .iReqSr04Rpt(iReqSr04Rpt),
    .iReqTempRpt(iReqTempRpt), .iReqHumRpt(iReqHumRpt),
    .iWatchHour(iWatchHour), .iWatchMin(iWatchMin), .iWatchSec(iWatchSec),
    .iSr04Cm(iSr04Cm), .iTempC(iTempC), .iHumPct(iHumPct),
    .oTxData(oTxData), .oTxValid(oTxValid), .iTxReady(iTxReady),
    .oBusy(oBusy), .oLoopDrop(oLoopDrop)
  );

  always #5 iClk = ~iClk;

  logic [7:0] expQ [$];
  int nChecks = 0;
  int nPass = 0;
  int accepted = 0;
  int dropCount = 0;
  int readyMode = 0;   // 0 = hold low, 1 = hold high, 2 = random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  always @(posedge iClk) begin
    #1;
    case (readyMode)
      0:       iTxReady = 1'b0;
      1:       iTxReady = 1'b1;
      default: iTxReady = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'h00;
  always @(negedge iClk) begin
    if (!iRstn) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall)
        check("stallHold", {23'd0, oTxValid, oTxData}, {23'd0, 1'b1, prevData});
      if (oTxValid && iTxReady) begin
        if (expQ.size() == 0) begin
          nChecks++;
          $display("FAIL txByte: got 0x%0h, expected no byte", oTxData);
        end else begin
          check("txByte", 32'(oTxData), 32'(expQ.pop_front()));
        end
        accepted++;
      end
      prevStall = oTxValid && !iTxReady;
      prevData  = oTxData;
    end
  end

  always @(negedge iClk) begin
    if (iRstn && oLoopDrop) dropCount++;
  end

  // ---------------- reference model: lines as text ----------------
  task automatic pushStr(input string s);
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
  endtask

  task automatic pushDec(input int v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      int p = 1;
      for (int j = 0; j < k; j++) p = p * 10;
      expQ.push_back(8'(8'h30 + (v / p) % 10));
    end
  endtask

  task automatic pushCrlf();
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
  endtask

  task automatic expectReports(input logic [3:0] m);
    if (m[0]) begin
      pushStr("W "); pushDec(int'(iWatchHour), 2); pushStr(":");
      pushDec(int'(iWatchMin), 2); pushStr(":"); pushDec(int'(iWatchSec), 2); pushCrlf();
    end
    if (m[1]) begin pushStr("D "); pushDec(int'(iSr04Cm), 3); pushStr("cm"); pushCrlf(); end
    if (m[2]) begin pushStr("T "); pushDec(int'(iTempC), 3);  pushStr("C");  pushCrlf(); end
    if (m[3]) begin pushStr("H "); pushDec(int'(iHumPct), 3); pushStr("%");  pushCrlf(); end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulseMask(input logic [3:0] m);
    iReqWatchRpt = m[0];
    iReqSr04Rpt  = m[1];
    iReqTempRpt  = m[2];
    iReqHumRpt   = m[3];
    step();
    {iReqHumRpt, iReqTempRpt, iReqSr04Rpt, iReqWatchRpt} = 4'b0000;
  endtask

  task automatic sendLoop(input logic [7:0] b);
    iLoopData  = b;
    iLoopValid = 1'b1;
    step();
    iLoopValid = 1'b0;
  endtask

  task automatic setReady(input int m);
    readyMode = m;
    repeat (2) step();
  endtask

  task automatic waitIdle(input string name, input int maxCyc);
    int n = 0;
    while (!(oBusy == 1'b0 && !oTxValid && expQ.size() == 0) && n < maxCyc) begin
      step();
      n++;
    end
    check(name, 32'(n < maxCyc), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int lat;
    int base;
    int nLoop;
    int n;
    logic [7:0] b;
    logic [3:0] mask;

    repeat (3) step();
    iRstn = 1'b1;

    // Quiet after reset
    bad = 0;
    repeat (100) begin
      step();
      if (oTxValid !== 1'b0 || oBusy !== 1'b0 || oTxData !== 8'h00) bad++;
    end
    check("idleQuietCycles", 32'(bad), 32'd0);
    check("idleTxData", 32'(oTxData), 32'h00);

    // SR04 37 with full readiness, plus first-byte latency
    setReady(1);
    iSr04Cm = 9'd37;
    expectReports(4'b0010);
    pulseMask(4'b0010);
    lat = 0;
    while (!oTxValid && lat < 60) begin
      step();
      lat++;
    end
    check("sr04Latency", 32'(lat <= 42), 32'd1);
    waitIdle("sr04Line", 200);

    // Re-request while the same line is being sent; new value only in the second line
    iSr04Cm = 9'd37;
    expectReports(4'b0010);
    base = accepted;
    pulseMask(4'b0010);
    n = 0;
    while (accepted == base && n < 100) begin
      step();
      n++;
    end
    check("reqDuringSendStart", 32'(accepted > base), 32'd1);
    iSr04Cm = 9'd400;
    expectReports(4'b0010);
    pulseMask(4'b0010);
    waitIdle("reqDuringSend", 300);

    // Watch 5:07:59 under random back-pressure
    readyMode = 2;
    iWatchHour = 5'd5; iWatchMin = 6'd7; iWatchSec = 6'd59;
    expectReports(4'b0001);
    pulseMask(4'b0001);
    waitIdle("watchStalled", 1000);

    // Loop bytes first, then temp and hum in fixed order
    setReady(0);
    iTempC = 8'd25;
    iHumPct = 8'd100;
    pushStr("abc");
    sendLoop("a");
    sendLoop("b");
    sendLoop("c");
    expectReports(4'b1100);
    pulseMask(4'b1100);
    readyMode = 1;
    waitIdle("echoThenTempHum", 500);

    // Overflow: 17 bytes into a 16-deep FIFO while blocked
    setReady(0);
    base = dropCount;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) expQ.push_back(b);
      sendLoop(b);
    end
    repeat (3) step();
    check("loopDropPulses", 32'(dropCount - base), 32'd1);
    readyMode = 1;
    waitIdle("overflowEcho", 500);

    // Randomized mixes of loop bytes and report requests
    for (int t = 0; t < 25; t++) begin
      setReady(0);
      iWatchHour = 5'($urandom_range(0, 23));
      iWatchMin  = 6'($urandom_range(0, 59));
      iWatchSec  = 6'($urandom_range(0, 59));
      iSr04Cm    = 9'($urandom_range(0, 511));
      iTempC     = 8'($urandom_range(0, 255));
      iHumPct    = 8'($urandom_range(0, 255));
      nLoop = $urandom_range(0, 4);
      mask  = 4'($urandom_range(0, 15));
      if (mask == 4'b0000 && nLoop == 0) mask = 4'b0001;
      for (int i = 0; i < nLoop; i++) begin
        b = 8'($urandom);
        expQ.push_back(b);
        sendLoop(b);
      end
      expectReports(mask);
      pulseMask(mask);
      if (nLoop > 0) pulseMask(mask & 4'($urandom_range(0, 15)));
      readyMode = $urandom_range(1, 2);
      waitIdle("randomTrial", 3000);
    end

    // Reset in the middle of a watch line
    setReady(1);
    iWatchHour = 5'd12; iWatchMin = 6'd34; iWatchSec = 6'd56;
    expectReports(4'b0001);
    base = accepted;
    pulseMask(4'b0001);
    n = 0;
    while (accepted < base + 4 && n < 200) begin
      step();
      n++;
    end
    check("rstAfterBytes", 32'(accepted - base), 32'd4);
    iRstn = 1'b0;
    #1;
    check("rstValidDrop", 32'(oTxValid), 32'd0);
    check("rstBusy", 32'(oBusy), 32'd0);
    check("rstTxData", 32'(oTxData), 32'h00);
    expQ.delete();
    repeat (2) step();
    iRstn = 1'b1;
    step();
    iSr04Cm = 9'd256;
    expectReports(4'b0010);
    pulseMask(4'b0010);
    waitIdle("postResetLine", 300);

    check("queueDrained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
